// File: rtl/int_ctrl.sv
// int_ctrl: programmable interrupt controller feeding one CP0 HWInt bit.
// Latches edge/level requests, applies masking and fixed priority, and handshakes with EXLSet/EXLClr.
module int_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_in,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  input  logic            exlset,
  input  logic            exlclr,
  output logic            int_out
);

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_VEC  = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] pend_next;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] edge_mode;
  logic [NSRC-1:0] irq_prev;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] ack_clr;
  logic            gen;

  logic [2:0]      cur_id;
  logic [2:0]      cur_id_next;
  logic [2:0]      win_id;
  logic            cur_valid;
  logic            cur_valid_next;
  logic            int_next;
  logic            any_elig;
  logic            cur_elig;

  logic            pend_wr;
  logic            mask_wr;
  logic            edge_wr;
  logic            unused_wd;

  assign pend_wr   = we && (addr == ADDR_PEND);
  assign mask_wr   = we && (addr == ADDR_MASK);
  assign edge_wr   = we && (addr == ADDR_EDGE);
  assign unused_wd = ^wd[30:NSRC];

  assign rise      = irq_in & ~irq_prev;
  assign w1c       = pend_wr ? wd[NSRC-1:0] : '0;
  assign elig      = pend & mask & {NSRC{gen}};
  assign any_elig  = |elig;

  // Edge bits: a new rising edge wins over any clear on the same cycle.
  // Level bits simply track the registered input.
  assign pend_next = (edge_mode & (rise | (pend & ~(w1c | ack_clr))))
                   | (~edge_mode & irq_in);

  always_comb begin
    ack_clr = '0;
    if (state == REQ && exlset) begin
      for (int i = 0; i < NSRC; i++) begin
        if (cur_id == 3'(i)) begin
          ack_clr[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_id = 3'(i);
      end
    end
  end

  always_comb begin
    cur_elig = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (cur_id == 3'(i)) begin
        cur_elig = elig[i];
      end
    end
  end

  // cur_id is frozen outside IDLE so a later higher-priority request never preempts.
  always_comb begin
    state_next     = state;
    cur_id_next    = cur_id;
    cur_valid_next = cur_valid;
    int_next       = 1'b0;
    case (state)
      IDLE: begin
        if (any_elig) begin
          state_next     = REQ;
          cur_id_next    = win_id;
          cur_valid_next = 1'b1;
          int_next       = 1'b1;
        end
      end
      REQ: begin
        int_next = 1'b1;
        if (exlset) begin
          state_next = SVC;
          int_next   = 1'b0;
        end else if (!cur_elig) begin
          state_next     = IDLE;
          int_next       = 1'b0;
          cur_valid_next = 1'b0;
          cur_id_next    = '0;
        end
      end
      SVC: begin
        if (exlclr) begin
          state_next     = IDLE;
          cur_valid_next = 1'b0;
        end
      end
      default: begin
        state_next     = IDLE;
        cur_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      mask      <= '0;
      gen       <= 1'b0;
      edge_mode <= '0;
      irq_prev  <= '0;
      cur_id    <= '0;
      cur_valid <= 1'b0;
      int_out   <= 1'b0;
    end else begin
      state     <= state_next;
      pend      <= pend_next;
      irq_prev  <= irq_in;
      cur_id    <= cur_id_next;
      cur_valid <= cur_valid_next;
      int_out   <= int_next;
      if (mask_wr) begin
        mask <= wd[NSRC-1:0];
        gen  <= wd[31];
      end
      if (edge_wr) begin
        edge_mode <= wd[NSRC-1:0];
      end
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      ADDR_PEND: rd[NSRC-1:0] = pend;
      ADDR_MASK: begin
        rd[NSRC-1:0] = mask;
        rd[31]       = gen;
      end
      ADDR_VEC: begin
        rd[2:0] = cur_id;
        rd[31]  = cur_valid;
      end
      ADDR_EDGE: rd[NSRC-1:0] = edge_mode;
      default:   rd = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: scoreboard bench for int_ctrl; a behavioural model queues expected int_out/rd per cycle
// and an independent negedge monitor pops and compares them, alongside directed scenario checks.
module tb_int_ctrl;

  localparam int NSRC = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq_in;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        exlset;
  logic        exlclr;
  logic        int_out;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];

  logic [5:0] m_pend, m_mask, m_edge, m_prev;
  logic       m_gen, m_raised, m_service, m_valid;
  int         m_id;

  int_ctrl #(.NSRC(NSRC)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .addr    (addr),
    .we      (we),
    .wd      (wd),
    .rd      (rd),
    .exlset  (exlset),
    .exlclr  (exlclr),
    .int_out (int_out)
  );

  always #50 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {26'b0, m_pend};
      2'd1:    return {m_gen, 25'b0, m_mask};
      2'd2:    return {m_valid, 28'b0, 3'(m_id)};
      default: return {26'b0, m_edge};
    endcase
  endfunction

  // Reference behaviour: one clock edge worth of the controller's rules.
  task automatic model_step(input logic [5:0] irq, input logic [1:0] a, input logic w,
                            input logic [31:0] d, input logic es, input logic ec, input logic r);
    logic [5:0] elig, npend;
    int win;
    if (r) begin
      m_pend = 0; m_mask = 0; m_edge = 0; m_prev = 0; m_gen = 0;
      m_raised = 0; m_service = 0; m_valid = 0; m_id = 0;
      return;
    end
    elig = m_pend & m_mask & {6{m_gen}};
    win = -1;
    for (int i = 5; i >= 0; i--) if (elig[i]) win = i;
    for (int i = 0; i < 6; i++) begin
      if (m_edge[i]) begin
        if (irq[i] && !m_prev[i]) npend[i] = 1'b1;
        else if ((w && a == 2'd0 && d[i]) || (m_raised && es && m_id == i)) npend[i] = 1'b0;
        else npend[i] = m_pend[i];
      end else begin
        npend[i] = irq[i];
      end
    end
    if (m_service) begin
      if (ec) begin m_service = 0; m_valid = 0; end
    end else if (m_raised) begin
      if (es) begin m_raised = 0; m_service = 1; end
      else if (!elig[m_id]) begin m_raised = 0; m_valid = 0; m_id = 0; end
    end else if (win >= 0) begin
      m_raised = 1; m_valid = 1; m_id = win;
    end
    if (w && a == 2'd1) begin m_mask = d[5:0]; m_gen = d[31]; end
    if (w && a == 2'd3) m_edge = d[5:0];
    m_pend = npend;
    m_prev = irq;
  endtask

  // Drive one cycle: queue what the DUT must show this cycle, advance the model, cross the edge.
  task automatic applyStimulus(input logic [5:0] irq, input logic [1:0] a, input logic w,
                               input logic [31:0] d, input logic es, input logic ec, input logic r);
    irq_in = irq; addr = a; we = w; wd = d; exlset = es; exlclr = ec; rst = r;
    exp_q.push_back({m_raised, model_read(a)});
    model_step(irq, a, w, d, es, ec, r);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [5:0] irq);
    applyStimulus(irq, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [5:0] irq, input logic [1:0] a, input logic [31:0] d);
    applyStimulus(irq, a, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkReg(input string name, input logic [1:0] a, input logic [31:0] expected);
    logic [1:0] saved;
    saved = addr;
    addr = a;
    #1;
    checkOutput(name, rd, expected);
    addr = saved;
    #1;
  endtask

  task automatic cleanup();
    wr(6'h00, 2'd1, 32'h0);
    wr(6'h00, 2'd0, 32'h3F);
    applyStimulus(6'h00, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(6'h00);
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("int_out", {31'b0, int_out}, {31'b0, e[32]});
      checkOutput($sformatf("rd[addr=%0d]", addr), rd, e[31:0]);
    end
  end

  initial begin
    logic [5:0] cur_irq;
    logic [1:0] a;
    logic [31:0] d;
    logic w, es, ec, r;

    irq_in = 6'h3F; addr = 0; we = 0; wd = 0; exlset = 0; exlclr = 0; rst = 1;
    model_step(6'h3F, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] reset");
    for (int i = 0; i < 4; i++) checkReg("reset_reg", 2'(i), 32'h0);
    checkOutput("reset_int", {31'b0, int_out}, 32'h0);
    applyStimulus(6'h3F, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) checkReg("reset_reg2", 2'(i), 32'h0);
    applyStimulus(6'h3F, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkReg("post_reset_pend", 2'd0, 32'h3F);
    checkOutput("post_reset_int", {31'b0, int_out}, 32'h0);
    step(6'h3F);
    checkOutput("post_reset_int2", {31'b0, int_out}, 32'h0);

    $display("[TB] priority and latency");
    step(6'h00);
    wr(6'h00, 2'd3, 32'h3F);
    wr(6'h00, 2'd1, 32'h8000_003F);
    step(6'h06);
    checkReg("prio_pend", 2'd0, 32'h06);
    checkOutput("prio_int_k", {31'b0, int_out}, 32'h0);
    step(6'h06);
    checkOutput("prio_int_k1", {31'b0, int_out}, 32'h1);
    checkReg("prio_vec", 2'd2, 32'h8000_0001);
    applyStimulus(6'h06, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkReg("ack_pend", 2'd0, 32'h04);
    checkOutput("ack_int", {31'b0, int_out}, 32'h0);
    applyStimulus(6'h06, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("eret_int", {31'b0, int_out}, 32'h0);
    step(6'h06);
    checkOutput("rearm_int", {31'b0, int_out}, 32'h1);
    checkReg("rearm_vec", 2'd2, 32'h8000_0002);
    applyStimulus(6'h06, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(6'h06, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("[TB] simultaneous set and clear");
    wr(6'h07, 2'd0, 32'h01);
    checkReg("w1c_vs_edge", 2'd0, 32'h01);
    step(6'h07);
    checkOutput("src0_req", {31'b0, int_out}, 32'h1);
    step(6'h06);
    applyStimulus(6'h07, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkReg("ack_vs_edge", 2'd0, 32'h01);
    checkOutput("ack_vs_edge_int", {31'b0, int_out}, 32'h0);
    applyStimulus(6'h07, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cleanup();

    $display("[TB] withdraw");
    wr(6'h00, 2'd3, 32'h37);
    wr(6'h00, 2'd1, 32'h8000_0008);
    step(6'h08);
    step(6'h08);
    checkOutput("wd_req", {31'b0, int_out}, 32'h1);
    checkReg("wd_vec", 2'd2, 32'h8000_0003);
    step(6'h00);
    checkReg("wd_pend", 2'd0, 32'h0);
    checkOutput("wd_int_hold", {31'b0, int_out}, 32'h1);
    step(6'h00);
    checkOutput("wd_int_drop", {31'b0, int_out}, 32'h0);
    checkReg("wd_vec_clr", 2'd2, 32'h0);
    cleanup();

    $display("[TB] no preemption");
    wr(6'h00, 2'd3, 32'h3F);
    wr(6'h00, 2'd1, 32'h8000_003F);
    step(6'h10);
    step(6'h10);
    checkReg("np_vec4", 2'd2, 32'h8000_0004);
    step(6'h11);
    step(6'h11);
    checkOutput("np_int", {31'b0, int_out}, 32'h1);
    checkReg("np_vec_hold", 2'd2, 32'h8000_0004);
    applyStimulus(6'h11, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkReg("np_vec_svc", 2'd2, 32'h8000_0004);
    checkReg("np_pend_svc", 2'd0, 32'h01);
    applyStimulus(6'h11, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(6'h11);
    checkOutput("np_next_int", {31'b0, int_out}, 32'h1);
    checkReg("np_next_vec", 2'd2, 32'h8000_0000);
    applyStimulus(6'h11, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(6'h11, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cleanup();

    $display("[TB] reset mid-service");
    wr(6'h00, 2'd1, 32'h8000_003F);
    step(6'h21);
    step(6'h21);
    applyStimulus(6'h21, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(6'h20);
    step(6'h21);
    checkReg("svc_pend", 2'd0, 32'h21);
    checkReg("svc_vec", 2'd2, 32'h8000_0000);
    applyStimulus(6'h21, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) checkReg("midrst_reg", 2'(i), 32'h0);
    checkOutput("midrst_int", {31'b0, int_out}, 32'h0);
    step(6'h21);
    step(6'h21);
    checkOutput("midrst_quiet", {31'b0, int_out}, 32'h0);
    wr(6'h21, 2'd1, 32'h8000_0021);
    checkOutput("reen_int_j", {31'b0, int_out}, 32'h0);
    step(6'h21);
    checkOutput("reen_int_j1", {31'b0, int_out}, 32'h1);
    checkReg("reen_vec", 2'd2, 32'h8000_0000);
    cleanup();

    $display("[TB] randomized traffic");
    cur_irq = 6'h00;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) cur_irq = cur_irq ^ (6'($urandom) & 6'($urandom));
      w = ($urandom_range(0, 7) == 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (w && a == 2'd1 && $urandom_range(0, 3) != 0) d[31] = 1'b1;
      es = m_raised ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 49) == 0);
      ec = m_service ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      r  = ($urandom_range(0, 499) == 0);
      applyStimulus(cur_irq, a, w, d, es, ec, r);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
